// File: rtl/dbus_master.sv
// dbus_master -- data-side bus initiator for the core's MEM stage.
//
// A pipeline load/store is accepted in IDLE and latched. One ACCESS phase
// follows on the external data bus, and it ends on the active-low ACKD_n
// acknowledge or on a timeout. A single DONE cycle then returns the
// extended load data with a one-cycle rdata_valid pulse. The pipeline is
// stalled from acceptance until DONE.
//
// Optional build macro:
//   DBUS_ALIGN_CHECK_EN  When defined, the following requests are rejected
//                        in IDLE without any bus cycle (misalign=1):
//                          - halfwords at odd addresses
//                          - words that are not 4-byte aligned
//                        When undefined, every address goes to the bus
//                        unchanged and misalign stays 0.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   req_valid    MEM stage has a load/store (held stable while stall=1)
//   req_write    1=store, 0=load
//   req_size     00 word, 01 half, 10/11 byte
//   req_signed   sign-extend half/byte loads
//   req_addr     byte address
//   req_wdata    store data, right-aligned
//   stall        hold pipeline (combinational)
//   rdata_valid  one-cycle completion pulse
//   rdata        extended load data (0 for stores and faults)
//   bus_err      completion was a timeout
//   misalign     completion was an alignment fault
//   DAD          bus address
//   MREQ         bus request
//   WRITE        bus direction, 1=store
//   SIZE         bus access size
//   DDT          bidirectional bus data; driven only during store ACCESS
//   ACKD_n       active-low acknowledge, sampled at rising clk

module dbus_master #(
  parameter int BIT_WIDTH = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [BIT_WIDTH-1:0] req_addr,
  input  logic [BIT_WIDTH-1:0] req_wdata,
  output logic                 stall,
  output logic                 rdata_valid,
  output logic [BIT_WIDTH-1:0] rdata,
  output logic                 bus_err,
  output logic                 misalign,
  output logic [BIT_WIDTH-1:0] DAD,
  output logic                 MREQ,
  output logic                 WRITE,
  output logic [1:0]           SIZE,
  inout  wire  [BIT_WIDTH-1:0] DDT,
  input  logic                 ACKD_n
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // The timeout fires on the edge that ends the TIMEOUT-th unacknowledged cycle.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t                 state_reg, state_next;
  logic [BIT_WIDTH-1:0]   addr_reg, addr_next;
  logic [1:0]             size_reg, size_next;
  logic                   write_reg, write_next;
  logic                   signed_reg, signed_next;
  logic [BIT_WIDTH-1:0]   ddt_out_reg, ddt_out_next;
  logic                   ddt_oe_reg, ddt_oe_next;
  logic                   mreq_reg, mreq_next;
  logic [7:0]             cnt_reg, cnt_next;
  logic [BIT_WIDTH-1:0]   rdata_reg, rdata_next;
  logic                   rdata_valid_reg, rdata_valid_next;
  logic                   bus_err_reg, bus_err_next;
  logic                   misalign_reg, misalign_next;

  logic                   misaligned;
  logic [BIT_WIDTH-1:0]   load_ext;
  logic [BIT_WIDTH-1:0]   store_data;

`ifdef DBUS_ALIGN_CHECK_EN
  assign misaligned = ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b00) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Loads arrive right-aligned on DDT; the responder owns lane placement.
  always_comb begin
    load_ext = DDT;
    case (size_reg)
      2'b00:   load_ext = DDT;
      2'b01:   load_ext = {{(BIT_WIDTH-16){signed_reg & DDT[15]}}, DDT[15:0]};
      default: load_ext = {{(BIT_WIDTH-8){signed_reg & DDT[7]}}, DDT[7:0]};
    endcase
  end

  // Store data is zero-padded above the access size and never lane-shifted.
  always_comb begin
    store_data = req_wdata;
    case (req_size)
      2'b00:   store_data = req_wdata;
      2'b01:   store_data = {{(BIT_WIDTH-16){1'b0}}, req_wdata[15:0]};
      default: store_data = {{(BIT_WIDTH-8){1'b0}}, req_wdata[7:0]};
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    size_next     = size_reg;
    write_next    = write_reg;
    signed_next   = signed_reg;
    ddt_out_next  = ddt_out_reg;
    cnt_next      = cnt_reg;
    rdata_next    = rdata_reg;
    bus_err_next  = bus_err_reg;
    misalign_next = misalign_reg;

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
            state_next    = DONE;
            rdata_next    = '0;
            bus_err_next  = 1'b0;
            misalign_next = 1'b1;
          end else begin
            state_next   = ACCESS;
            addr_next    = req_addr;
            size_next    = req_size;
            write_next   = req_write;
            signed_next  = req_signed;
            ddt_out_next = store_data;
          end
        end
      end
      ACCESS: begin
        // An acknowledge wins over a timeout that lands on the same edge.
        if (!ACKD_n) begin
          state_next    = DONE;
          rdata_next    = write_reg ? '0 : load_ext;
          bus_err_next  = 1'b0;
          misalign_next = 1'b0;
          cnt_next      = '0;
        end else if (cnt_reg == TIMEOUT_LAST) begin
          state_next    = DONE;
          rdata_next    = '0;
          bus_err_next  = 1'b1;
          misalign_next = 1'b0;
          cnt_next      = '0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Bus strobes are registered copies of the state being entered.
    mreq_next        = (state_next == ACCESS);
    ddt_oe_next      = (state_next == ACCESS) && write_next;
    rdata_valid_next = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      size_reg        <= 2'b00;
      write_reg       <= 1'b0;
      signed_reg      <= 1'b0;
      ddt_out_reg     <= '0;
      ddt_oe_reg      <= 1'b0;
      mreq_reg        <= 1'b0;
      cnt_reg         <= '0;
      rdata_reg       <= '0;
      rdata_valid_reg <= 1'b0;
      bus_err_reg     <= 1'b0;
      misalign_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      size_reg        <= size_next;
      write_reg       <= write_next;
      signed_reg      <= signed_next;
      ddt_out_reg     <= ddt_out_next;
      ddt_oe_reg      <= ddt_oe_next;
      mreq_reg        <= mreq_next;
      cnt_reg         <= cnt_next;
      rdata_reg       <= rdata_next;
      rdata_valid_reg <= rdata_valid_next;
      bus_err_reg     <= bus_err_next;
      misalign_reg    <= misalign_next;
    end
  end

  assign stall       = (state_reg == ACCESS) || ((state_reg == IDLE) && req_valid);
  assign rdata_valid = rdata_valid_reg;
  assign rdata       = rdata_reg;
  assign bus_err     = bus_err_reg;
  assign misalign    = misalign_reg;
  assign DAD         = addr_reg;
  assign MREQ        = mreq_reg;
  assign WRITE       = write_reg;
  assign SIZE        = size_reg;
  assign DDT         = ddt_oe_reg ? ddt_out_reg : {BIT_WIDTH{1'bz}};

endmodule

// File: tb/tb_dbus_master.sv
// Self-checking bench for dbus_master: directed load/store vectors against a
// behavioural responder; DDT is a pulled-up net so a released bus reads all ones.

module tb_dbus_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rdata_valid, bus_err, misalign, MREQ, WRITE;
  logic [31:0] rdata, DAD;
  logic [1:0]  SIZE;
  logic        ACKD_n;
  tri1  [31:0] DDT;
  logic        resp_oe;
  logic [31:0] resp_data;

  assign DDT = resp_oe ? resp_data : 32'hzzzzzzzz;

  always #5 clk = ~clk;

  dbus_master #(.BIT_WIDTH(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata_valid(rdata_valid), .rdata(rdata),
    .bus_err(bus_err), .misalign(misalign),
    .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
    .DDT(DDT), .ACKD_n(ACKD_n)
  );

  int checks = 0;
  int failures = 0;

  // Observations gathered by run_access for the calling test to judge.
  int          r_mreq, r_stall, r_valid, r_valid_cyc, r_extra_valid, r_extra_mreq;
  logic [31:0] r_rdata, r_dad, r_ddt_bus, r_ddt_done;
  logic [1:0]  r_size;
  logic        r_write, r_err, r_mis;

  // One request, responder acks in the lat-th ACCESS cycle (lat=0: never).
  task automatic run_access(input logic wr, input logic [1:0] sz, input logic sg,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int lat, input logic [31:0] resp, input int limit);
    int cyc;
    bit done;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    r_mreq = 0; r_stall = 0; r_valid = 0; r_valid_cyc = -1;
    r_extra_valid = 0; r_extra_mreq = 0;
    r_rdata = '0; r_dad = '0; r_ddt_bus = '0; r_ddt_done = '0;
    r_size = 2'b00; r_write = 1'b0; r_err = 1'b0; r_mis = 1'b0;
    #1;
    if (stall) r_stall++;
    if (MREQ) r_mreq++;
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < limit) begin
      @(posedge clk); #1;
      ACKD_n = 1'b1; resp_oe = 1'b0;
      cyc++;
      @(negedge clk);
      if (stall) r_stall++;
      if (MREQ) begin
        r_mreq++; r_dad = DAD; r_size = SIZE; r_write = WRITE; r_ddt_bus = DDT;
        if (lat > 0 && r_mreq >= lat) begin
          ACKD_n = 1'b0;
          if (!wr) begin resp_oe = 1'b1; resp_data = resp; end
        end
      end
      if (rdata_valid) begin
        r_valid++; r_valid_cyc = cyc; r_rdata = rdata; r_err = bus_err;
        r_mis = misalign; r_ddt_done = DDT; req_valid = 1'b0; done = 1'b1;
      end
    end
    req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (rdata_valid) r_extra_valid++;
      if (MREQ) r_extra_mreq++;
    end
    $display("txn wr=%0b size=%b addr=%h wdata=%h lat=%0d -> mreq=%0d valid_cyc=%0d rdata=%h err=%0b mis=%0b",
             wr, sz, addr, wd, lat, r_mreq, r_valid_cyc, r_rdata, r_err, r_mis);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (MREQ !== 1'b0) begin failures++; $display("FAIL reset_mreq: got %b expected 0", MREQ); end
    checks++; if (WRITE !== 1'b0) begin failures++; $display("FAIL reset_write: got %b expected 0", WRITE); end
    checks++; if (SIZE !== 2'b00) begin failures++; $display("FAIL reset_size: got %b expected 00", SIZE); end
    checks++; if (DAD !== 32'h0) begin failures++; $display("FAIL reset_dad: got %h expected 0", DAD); end
    checks++; if (DDT !== 32'hFFFFFFFF) begin failures++; $display("FAIL reset_ddt: got %h expected released", DDT); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if ({rdata_valid, bus_err, misalign, stall} !== 4'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 0000", {rdata_valid, bus_err, misalign, stall}); end
    rst = 1'b1;
    @(negedge clk);
    $display("txn reset released");
  endtask

  task automatic test_word_load;
    run_access(1'b0, 2'b00, 1'b0, 32'h08000010, 32'h0, 1, 32'hDEADBEEF, 20);
    checks++; if (r_mreq !== 1) begin failures++; $display("FAIL word_mreq_cycles: got %0d expected 1", r_mreq); end
    checks++; if ({r_write, r_size} !== 3'b000) begin failures++; $display("FAIL word_write_size: got %b expected 000", {r_write, r_size}); end
    checks++; if (r_dad !== 32'h08000010) begin failures++; $display("FAIL word_dad: got %h expected 08000010", r_dad); end
    checks++; if (r_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL word_rdata: got %h expected deadbeef", r_rdata); end
    checks++; if (r_valid_cyc !== 2) begin failures++; $display("FAIL word_latency: got %0d expected 2", r_valid_cyc); end
    checks++; if (r_stall !== 2) begin failures++; $display("FAIL word_stall_cycles: got %0d expected 2", r_stall); end
    checks++; if (r_valid + r_extra_valid !== 1) begin failures++; $display("FAIL word_valid_pulses: got %0d expected 1", r_valid + r_extra_valid); end
    checks++; if ({r_err, r_mis} !== 2'b00) begin failures++; $display("FAIL word_err_mis: got %b expected 00", {r_err, r_mis}); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL word_rdata_hold: got %h expected deadbeef", rdata); end
  endtask

  task automatic test_ext_loads;
    logic [1:0]  t_size [6] = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b10};
    logic        t_sgn  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] t_resp [6] = '{32'h00000080, 32'h00000080, 32'h00008001,
                                32'hFFFF8001, 32'h1234567F, 32'hABCDEFF0};
    logic [31:0] t_exp  [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001,
                                32'h00008001, 32'h0000007F, 32'hFFFFFFF0};
    for (int i = 0; i < 6; i++) begin
      run_access(1'b0, t_size[i], t_sgn[i], 32'h00001000 + 32'(i), 32'h0, 1, t_resp[i], 20);
      checks++; if (r_rdata !== t_exp[i]) begin failures++; $display("FAIL ext_load_%0d: got %h expected %h", i, r_rdata, t_exp[i]); end
      checks++; if (r_size !== t_size[i]) begin failures++; $display("FAIL ext_size_%0d: got %b expected %b", i, r_size, t_size[i]); end
    end
  endtask

  task automatic test_stores;
    logic [1:0]  t_size [4] = '{2'b10, 2'b01, 2'b00, 2'b11};
    logic [31:0] t_addr [4] = '{32'hF0000000, 32'hF0000002, 32'hF0000004, 32'hF0000007};
    logic [31:0] t_wd   [4] = '{32'h12345641, 32'hAAAA1234, 32'hCAFEF00D, 32'h876543C5};
    logic [31:0] t_exp  [4] = '{32'h00000041, 32'h00001234, 32'hCAFEF00D, 32'h000000C5};
    for (int i = 0; i < 4; i++) begin
      run_access(1'b1, t_size[i], 1'b0, t_addr[i], t_wd[i], 1, 32'h0, 20);
      checks++; if (r_ddt_bus !== t_exp[i]) begin failures++; $display("FAIL store_ddt_%0d: got %h expected %h", i, r_ddt_bus, t_exp[i]); end
      checks++; if ({r_write, r_size} !== {1'b1, t_size[i]}) begin
        failures++; $display("FAIL store_write_size_%0d: got %b expected %b", i, {r_write, r_size}, {1'b1, t_size[i]}); end
      checks++; if (r_dad !== t_addr[i]) begin failures++; $display("FAIL store_dad_%0d: got %h expected %h", i, r_dad, t_addr[i]); end
      checks++; if (r_ddt_done !== 32'hFFFFFFFF) begin failures++; $display("FAIL store_ddt_release_%0d: got %h expected released", i, r_ddt_done); end
      checks++; if (r_rdata !== 32'h0 || r_valid !== 1) begin
        failures++; $display("FAIL store_complete_%0d: got rdata=%h valid=%0d expected 0/1", i, r_rdata, r_valid); end
    end
  endtask

  task automatic test_latency3;
    run_access(1'b0, 2'b00, 1'b0, 32'h00002000, 32'h0, 3, 32'h13579BDF, 20);
    checks++; if (r_mreq !== 3) begin failures++; $display("FAIL lat3_mreq_cycles: got %0d expected 3", r_mreq); end
    checks++; if (r_valid + r_extra_valid !== 1) begin failures++; $display("FAIL lat3_valid_pulses: got %0d expected 1", r_valid + r_extra_valid); end
    checks++; if (r_valid_cyc !== 4) begin failures++; $display("FAIL lat3_latency: got %0d expected 4", r_valid_cyc); end
    checks++; if (r_rdata !== 32'h13579BDF) begin failures++; $display("FAIL lat3_rdata: got %h expected 13579bdf", r_rdata); end
  endtask

  task automatic test_timeout;
    run_access(1'b0, 2'b00, 1'b0, 32'h00003000, 32'h0, 0, 32'h0, 300);
    checks++; if (r_mreq !== 255) begin failures++; $display("FAIL timeout_mreq_cycles: got %0d expected 255", r_mreq); end
    checks++; if (r_valid !== 1 || r_valid_cyc !== 256) begin
      failures++; $display("FAIL timeout_done: got valid=%0d cyc=%0d expected 1/256", r_valid, r_valid_cyc); end
    checks++; if ({r_err, r_mis} !== 2'b10) begin failures++; $display("FAIL timeout_err: got %b expected 10", {r_err, r_mis}); end
    checks++; if (r_rdata !== 32'h0) begin failures++; $display("FAIL timeout_rdata: got %h expected 0", r_rdata); end
    checks++; if (r_extra_mreq !== 0) begin failures++; $display("FAIL timeout_mreq_drop: got %0d expected 0", r_extra_mreq); end
  endtask

  task automatic test_async_reset;
    int vcount;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h00000100; req_wdata = 32'h12345699;
    @(negedge clk);
    @(negedge clk);
    checks++; if (MREQ !== 1'b1 || DDT !== 32'h00000099) begin
      failures++; $display("FAIL arst_pre: got mreq=%b ddt=%h expected 1/00000099", MREQ, DDT); end
    #2 rst = 1'b0;
    #1;
    checks++; if (MREQ !== 1'b0) begin failures++; $display("FAIL arst_mreq: got %b expected 0", MREQ); end
    checks++; if (DDT !== 32'hFFFFFFFF) begin failures++; $display("FAIL arst_ddt: got %h expected released", DDT); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL arst_bus_err: got %b expected 0", bus_err); end
    req_valid = 1'b0;
    vcount = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rdata_valid || MREQ) vcount++;
    end
    checks++; if (vcount !== 0) begin failures++; $display("FAIL arst_no_completion: got %0d expected 0", vcount); end
    rst = 1'b1;
    $display("txn async reset mid-access");
    run_access(1'b0, 2'b00, 1'b0, 32'h00000200, 32'h0, 2, 32'h0BADF00D, 20);
    checks++; if (r_rdata !== 32'h0BADF00D || r_mreq !== 2) begin
      failures++; $display("FAIL arst_recover: got rdata=%h mreq=%0d expected 0badf00d/2", r_rdata, r_mreq); end
  endtask

  task automatic test_ack_held;
    int bad;
    bad = 0;
    @(negedge clk);
    ACKD_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rdata_valid || MREQ) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL ack_held_idle: got %0d expected 0", bad); end
    run_access(1'b0, 2'b00, 1'b0, 32'h00000300, 32'h0, 2, 32'h24681357, 20);
    checks++; if (r_mreq !== 2 || r_rdata !== 32'h24681357) begin
      failures++; $display("FAIL ack_held_access: got mreq=%0d rdata=%h expected 2/24681357", r_mreq, r_rdata); end
  endtask

  // Expected per-cycle pattern: IDLE, ACCESS, DONE, IDLE, ACCESS, DONE, IDLE, IDLE.
  task automatic test_back_to_back;
    logic [7:0]  mreq_tr, valid_tr, stall_tr;
    logic [31:0] rd0, rd1;
    int nv, acc;
    mreq_tr = '0; valid_tr = '0; stall_tr = '0; rd0 = '0; rd1 = '0; nv = 0; acc = 0;
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
        req_addr = 32'h00004000; req_wdata = 32'h0;
        #1;
      end else begin
        @(posedge clk); #1;
        ACKD_n = 1'b1; resp_oe = 1'b0;
        @(negedge clk);
      end
      mreq_tr[c] = MREQ; valid_tr[c] = rdata_valid; stall_tr[c] = stall;
      if (MREQ) begin
        ACKD_n = 1'b0; resp_oe = 1'b1;
        resp_data = (acc == 0) ? 32'h11112222 : 32'h000000FE;
        acc++;
      end
      if (rdata_valid) begin
        if (nv == 0) rd0 = rdata; else rd1 = rdata;
        nv++;
        if (nv == 1) begin
          req_size = 2'b10; req_signed = 1'b1; req_addr = 32'h00004005;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    $display("txn back_to_back mreq=%b valid=%b stall=%b rd0=%h rd1=%h", mreq_tr, valid_tr, stall_tr, rd0, rd1);
    checks++; if (mreq_tr !== 8'b00010010) begin failures++; $display("FAIL b2b_mreq_trace: got %b expected 00010010", mreq_tr); end
    checks++; if (valid_tr !== 8'b00100100) begin failures++; $display("FAIL b2b_valid_trace: got %b expected 00100100", valid_tr); end
    checks++; if (stall_tr !== 8'b00011011) begin failures++; $display("FAIL b2b_stall_trace: got %b expected 00011011", stall_tr); end
    checks++; if (rd0 !== 32'h11112222 || rd1 !== 32'hFFFFFFFE) begin
      failures++; $display("FAIL b2b_rdata: got %h/%h expected 11112222/fffffffe", rd0, rd1); end
  endtask

  task automatic test_unaligned;
    run_access(1'b0, 2'b00, 1'b0, 32'h08000002, 32'h0, 1, 32'h55AA55AA, 20);
`ifdef DBUS_ALIGN_CHECK_EN
    checks++; if (r_mreq !== 0) begin failures++; $display("FAIL unal_word_mreq: got %0d expected 0", r_mreq); end
    checks++; if (r_mis !== 1'b1 || r_err !== 1'b0) begin failures++; $display("FAIL unal_word_flags: got %b expected 10", {r_mis, r_err}); end
    checks++; if (r_rdata !== 32'h0 || r_valid_cyc !== 1) begin
      failures++; $display("FAIL unal_word_done: got rdata=%h cyc=%0d expected 0/1", r_rdata, r_valid_cyc); end
`else
    checks++; if (r_mreq !== 1 || r_dad !== 32'h08000002) begin
      failures++; $display("FAIL unal_word_bus: got mreq=%0d dad=%h expected 1/08000002", r_mreq, r_dad); end
    checks++; if (r_mis !== 1'b0) begin failures++; $display("FAIL unal_word_mis: got %b expected 0", r_mis); end
    checks++; if (r_rdata !== 32'h55AA55AA || r_valid_cyc !== 2) begin
      failures++; $display("FAIL unal_word_done: got rdata=%h cyc=%0d expected 55aa55aa/2", r_rdata, r_valid_cyc); end
`endif
    run_access(1'b0, 2'b01, 1'b0, 32'h08000003, 32'h0, 1, 32'h00009876, 20);
`ifdef DBUS_ALIGN_CHECK_EN
    checks++; if (r_mreq !== 0 || r_mis !== 1'b1) begin
      failures++; $display("FAIL unal_half: got mreq=%0d mis=%b expected 0/1", r_mreq, r_mis); end
`else
    checks++; if (r_mreq !== 1 || r_rdata !== 32'h00009876) begin
      failures++; $display("FAIL unal_half: got mreq=%0d rdata=%h expected 1/00009876", r_mreq, r_rdata); end
`endif
    // Odd byte addresses are always legal.
    run_access(1'b0, 2'b10, 1'b0, 32'h08000003, 32'h0, 1, 32'h000000A5, 20);
    checks++; if (r_mreq !== 1 || r_mis !== 1'b0 || r_rdata !== 32'h000000A5) begin
      failures++; $display("FAIL unal_byte: got mreq=%0d mis=%b rdata=%h expected 1/0/000000a5", r_mreq, r_mis, r_rdata); end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; ACKD_n = 1'b1; resp_oe = 1'b0; resp_data = '0;
    test_reset();
    test_word_load();
    test_ext_loads();
    test_stores();
    test_latency3();
    test_timeout();
    test_async_reset();
    test_ack_held();
    test_back_to_back();
    test_unaligned();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dbus_master.md
Name: dbus_master

Overview:
Data-side bus initiator inside the core. It takes load/store requests from the pipeline MEM stage and drives the external data bus (DAD/DDT/MREQ/WRITE/SIZE). It waits on the active-low ACKD_n handshake, then returns extended load data to the pipeline. It stalls the pipeline for the whole transaction.

Parameters:
BIT_WIDTH, 32, address/data width
TIMEOUT, 255, max cycles in ACCESS without ACKD_n before bus error (8-bit counter)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  1  MEM stage has a load/store; held stable while stall=1
req_write  input  1  1=store, 0=load
req_size  input  2  00 word, 01 half, 10 byte, 11 treated as byte
req_signed  input  1  sign-extend load (half/byte)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
stall  output  1  hold pipeline
rdata_valid  output  1  one-cycle completion pulse
rdata  output  32  extended load data
bus_err  output  1  completion was a timeout
misalign  output  1  completion was an alignment fault (0 unless DBUS_ALIGN_CHECK_EN)
DAD  output  32  bus address
MREQ  output  1  bus request
WRITE  output  1  bus direction, 1=store
SIZE  output  2  bus access size
DDT  inout  32  bus data; driven only during store ACCESS, else high-Z
ACKD_n  input  1  active-low acknowledge, sampled at rising clk

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst.
- Reset values: state=IDLE, MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT=Z, rdata=0, rdata_valid=0, bus_err=0, misalign=0, timeout counter=0.
- Reset during a transaction: MREQ drops and DDT tri-states immediately, asynchronously. No completion pulse is produced.
- All bus outputs are registered. stall is combinational: stall = (state==ACCESS) | (state==IDLE & req_valid).
- IDLE: on a rising edge with req_valid=1, latch addr/size/write/signed/wdata and go to ACCESS. In IDLE, ACKD_n is ignored.
- ACCESS:
  - Drive MREQ=1, DAD=latched addr, SIZE=latched size, WRITE=latched write.
  - Store data on DDT: word = wdata; half = {16'b0, wdata[15:0]}; byte/11 = {24'b0, wdata[7:0]}.
  - The responder handles big-endian lane placement. The master never shifts lanes.
- ACKD_n=0 sampled while in ACCESS:
  - Load: capture DDT.
    - word: as-is.
    - half: DDT[15:0], sign- or zero-extended per signed.
    - byte: DDT[7:0], extended likewise.
  - Store: rdata=0.
  - Go to DONE. MREQ=0 and DDT=Z from the next cycle.
- Timeout: the counter increments each ACCESS cycle without ack. When it reaches TIMEOUT, go to DONE with bus_err=1 and rdata=0. The counter clears on leaving ACCESS.
- DONE (exactly one cycle): rdata_valid=1, stall=0, MREQ=0. The pipeline advances at this edge. req_valid is ignored in DONE. Next state is IDLE.
- Timing with a 1-cycle responder: IDLE edge → ACCESS (ack at first edge) → DONE, i.e. 3 cycles per access. Back-to-back requests have one IDLE cycle between MREQ pulses.
- ACKD_n held low continuously by the responder is harmless, since it is sampled only in ACCESS.
- rdata, bus_err and misalign hold their values until the next DONE.

Optional Feature:
- Macro: DBUS_ALIGN_CHECK_EN.
- Defined: in IDLE, a request is misaligned if it is a half with addr[0]=1, or a word with addr[1:0]≠00. A misaligned request goes directly IDLE→DONE with misalign=1 and rdata=0. No MREQ is asserted.
- Undefined: the address is passed through unchanged and misalign is tied 0.

Test Plan:
- Word load at 0x08000010, responder latency 1, DDT=0xDEADBEEF → MREQ=1 for 1 cycle, WRITE=0, SIZE=00; rdata=0xDEADBEEF with rdata_valid pulse 2 cycles after accept; stall high 2 cycles.
- Signed byte load, DDT=0x00000080 → rdata=0xFFFFFF80. Same with req_signed=0 → 0x00000080. Half load with DDT=0x00008001, signed → 0xFFFF8001.
- Byte store to 0xF0000000 with wdata=0x12345641, SIZE=10 → DDT=0x00000041 while MREQ=1, high-Z after; half store with wdata=0xAAAA1234 → DDT=0x00001234.
- Responder latency 3 → MREQ held 3 cycles, exactly one rdata_valid. Responder never acks → bus_err=1 after 255 ACCESS cycles, MREQ drops.
- rst pulled low mid-ACCESS → MREQ=0 and DDT=Z with no clock edge; no rdata_valid. After release, a new request completes normally.
- With DBUS_ALIGN_CHECK_EN: word load at 0x08000002 → no MREQ, misalign=1, rdata_valid next cycle. Without the macro → normal bus cycle to 0x08000002.
